// File: rtl/recirc_pkg.sv
// Shared types and helpers for the recirculation router.
package recirc_pkg;

  typedef enum logic [0:0] {
    ST_ROUTE,
    ST_DRAIN
  } state_e;

  localparam logic ROUTE_MUX = 1'b1;
  localparam logic ROUTE_PRB = 1'b0;

  // Widest counter sat_add can handle; callers zero-extend into this width.
  localparam int unsigned MAX_CNT_W = 32;

  // Adds inc to cnt and clamps the result at 2^cnt_w-1.
  function automatic logic [MAX_CNT_W-1:0] sat_add(input logic [MAX_CNT_W-1:0] cnt,
                                                   input logic [MAX_CNT_W-1:0] inc,
                                                   input int unsigned          cnt_w);
    logic [MAX_CNT_W:0] sum;
    logic [MAX_CNT_W:0] lim;
    lim = ({{MAX_CNT_W{1'b0}}, 1'b1} << cnt_w) - {{MAX_CNT_W{1'b0}}, 1'b1};
    sum = {1'b0, cnt} + {1'b0, inc};
    if (sum > lim) begin
      sum = lim;
    end
    return sum[MAX_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/recirc_lane.sv
// One lane of the router: a registered 1-to-2 demux steered by the committed route.
module recirc_lane
  import recirc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             route_mux_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] mux_data_o,
  output logic             mux_valid_o,
  output logic [WIDTH-1:0] prb_data_o,
  output logic             prb_valid_o
);

  logic [WIDTH-1:0] mux_data_q;
  logic             mux_valid_q;
  logic [WIDTH-1:0] prb_data_q;
  logic             prb_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mux_data_q  <= '0;
      mux_valid_q <= 1'b0;
      prb_data_q  <= '0;
      prb_valid_q <= 1'b0;
    end else if (route_mux_i == ROUTE_MUX) begin
      mux_data_q  <= data_i;
      mux_valid_q <= valid_i;
      prb_data_q  <= '0;
      prb_valid_q <= 1'b0;
    end else begin
      mux_data_q  <= '0;
      mux_valid_q <= 1'b0;
      prb_data_q  <= data_i;
      prb_valid_q <= valid_i;
    end
  end

  assign mux_data_o  = mux_data_q;
  assign mux_valid_o = mux_valid_q;
  assign prb_data_o  = prb_data_q;
  assign prb_valid_o = prb_valid_q;

endmodule

// File: rtl/recirc_router.sv
// N-lane recirculation router: glitch-free route switching after an idle gap,
// with saturating per-destination beat counters.
module recirc_router
  import recirc_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned GAP_CYC     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_ROUTE = ROUTE_MUX
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  input  logic [LANES-1:0]       in_valid_i,
  input  logic                   recirc_sel_i,
  input  logic                   cnt_clr_i,
  output logic [LANES*WIDTH-1:0] mux_data_o,
  output logic [LANES-1:0]       mux_valid_o,
  output logic [LANES*WIDTH-1:0] prb_data_o,
  output logic [LANES-1:0]       prb_valid_o,
  output logic                   route_mux_o,
  output logic                   switch_pend_o,
  output logic [CNT_W-1:0]       mux_beats_o,
  output logic [CNT_W-1:0]       prb_beats_o
);

  localparam int unsigned IDLE_W = $clog2(GAP_CYC) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(GAP_CYC - 1);

  state_e            state_q;
  logic              route_q;
  logic              pend_q;
  logic [IDLE_W-1:0] idle_run_q;

  logic [CNT_W-1:0]     mux_cnt_q, mux_cnt_d;
  logic [CNT_W-1:0]     prb_cnt_q, prb_cnt_d;
  logic [MAX_CNT_W-1:0] pop_cnt;
  logic [MAX_CNT_W-1:0] mux_sum, prb_sum;
  logic                 unused_sum;

  // The old route keeps carrying traffic until a full idle gap is seen, so a
  // commit can only happen on a cycle with no valid beat in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_ROUTE;
      route_q    <= RESET_ROUTE;
      pend_q     <= 1'b0;
      idle_run_q <= '0;
    end else begin
      case (state_q)
        ST_ROUTE: begin
          if (recirc_sel_i != route_q) begin
            state_q    <= ST_DRAIN;
            idle_run_q <= '0;
            pend_q     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (recirc_sel_i == route_q) begin
            state_q <= ST_ROUTE;
            pend_q  <= 1'b0;
          end else if (|in_valid_i) begin
            idle_run_q <= '0;
          end else if (idle_run_q == IDLE_LAST) begin
            route_q <= ~route_q;
            pend_q  <= 1'b0;
            state_q <= ST_ROUTE;
          end else begin
            idle_run_q <= idle_run_q + IDLE_W'(1);
          end
        end
        default: state_q <= ST_ROUTE;
      endcase
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop_cnt = pop_cnt + MAX_CNT_W'(in_valid_i[i]);
    end
  end

  assign mux_sum    = sat_add(MAX_CNT_W'(mux_cnt_q), pop_cnt, CNT_W);
  assign prb_sum    = sat_add(MAX_CNT_W'(prb_cnt_q), pop_cnt, CNT_W);
  assign unused_sum = ^{mux_sum, prb_sum};

  // Beats are credited to whichever side receives this cycle's sample.
  always_comb begin
    mux_cnt_d = mux_cnt_q;
    prb_cnt_d = prb_cnt_q;
    if (cnt_clr_i) begin
      mux_cnt_d = '0;
      prb_cnt_d = '0;
    end else if (route_q == ROUTE_MUX) begin
      mux_cnt_d = mux_sum[CNT_W-1:0];
    end else begin
      prb_cnt_d = prb_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mux_cnt_q <= '0;
      prb_cnt_q <= '0;
    end else begin
      mux_cnt_q <= mux_cnt_d;
      prb_cnt_q <= prb_cnt_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    recirc_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (reset_i),
      .route_mux_i(route_q),
      .data_i     (in_data_i[g*WIDTH +: WIDTH]),
      .valid_i    (in_valid_i[g]),
      .mux_data_o (mux_data_o[g*WIDTH +: WIDTH]),
      .mux_valid_o(mux_valid_o[g]),
      .prb_data_o (prb_data_o[g*WIDTH +: WIDTH]),
      .prb_valid_o(prb_valid_o[g])
    );
  end

  assign route_mux_o   = route_q;
  assign switch_pend_o = pend_q;
  assign mux_beats_o   = mux_cnt_q;
  assign prb_beats_o   = prb_cnt_q;

endmodule

// File: tb/tb_recirc_router.sv
// Directed-vector bench for recirc_router: one instance with GAP_CYC=1/CNT_W=16 and one
// with GAP_CYC=3/CNT_W=4, both driven from the same inputs.
module tb_recirc_router;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        recirc_sel;
  logic        cnt_clr;

  logic [31:0] a_md, a_pd, b_md, b_pd;
  logic [3:0]  a_mv, a_pv, b_mv, b_pv;
  logic        a_route, a_pend, b_route, b_pend;
  logic [15:0] a_mb, a_pb;
  logic [3:0]  b_mb, b_pb;

  int n_vec = 0;
  int n_err = 0;

  recirc_router #(
    .LANES(4), .WIDTH(8), .GAP_CYC(1), .CNT_W(16), .RESET_ROUTE(1'b1)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .recirc_sel_i(recirc_sel), .cnt_clr_i(cnt_clr),
    .mux_data_o(a_md), .mux_valid_o(a_mv), .prb_data_o(a_pd), .prb_valid_o(a_pv),
    .route_mux_o(a_route), .switch_pend_o(a_pend), .mux_beats_o(a_mb), .prb_beats_o(a_pb)
  );

  recirc_router #(
    .LANES(4), .WIDTH(8), .GAP_CYC(3), .CNT_W(4), .RESET_ROUTE(1'b1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .recirc_sel_i(recirc_sel), .cnt_clr_i(cnt_clr),
    .mux_data_o(b_md), .mux_valid_o(b_mv), .prb_data_o(b_pd), .prb_valid_o(b_pv),
    .route_mux_o(b_route), .switch_pend_o(b_pend), .mux_beats_o(b_mb), .prb_beats_o(b_pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        sel;
    logic        clr;
    logic        e_route;
    logic        e_pend;
    logic [3:0]  e_mv;
    logic [31:0] e_md;
    logic [3:0]  e_pv;
    logic [31:0] e_pd;
    logic [15:0] e_mb;
    logic [15:0] e_pb;
  } vec_t;

  vec_t tbl [19];
  logic [3:0] gap_v [7];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic s,
                              input logic c, input logic r, input logic p,
                              input logic [3:0] mv, input logic [31:0] md,
                              input logic [3:0] pv, input logic [31:0] pd,
                              input logic [15:0] mb, input logic [15:0] pb);
    vec_t t;
    t.valid = v; t.data = d; t.sel = s; t.clr = c; t.e_route = r; t.e_pend = p;
    t.e_mv = mv; t.e_md = md; t.e_pv = pv; t.e_pd = pd; t.e_mb = mb; t.e_pb = pb;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; recirc_sel = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic       m_route, m_pend;
    int         m_mb, m_pb, total;
    logic [3:0] exp_mv, exp_pv;
    logic [31:0] exp_md, exp_pd;

    // Steering, drain, cancel, clear and toggling on the GAP_CYC=1 instance.
    tbl[0]  = mk(4'hF, 32'h11223344, 1, 0, 1, 0, 4'hF, 32'h11223344, 4'h0, 0, 4, 0);
    tbl[1]  = mk(4'hF, 32'h55667788, 1, 0, 1, 0, 4'hF, 32'h55667788, 4'h0, 0, 8, 0);
    tbl[2]  = mk(4'hF, 32'h99AABBCC, 0, 0, 1, 1, 4'hF, 32'h99AABBCC, 4'h0, 0, 12, 0);
    tbl[3]  = mk(4'hF, 32'hDDEEFF00, 0, 0, 1, 1, 4'hF, 32'hDDEEFF00, 4'h0, 0, 16, 0);
    tbl[4]  = mk(4'hF, 32'h01020304, 0, 0, 1, 1, 4'hF, 32'h01020304, 4'h0, 0, 20, 0);
    tbl[5]  = mk(4'h0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0, 4'h0, 0, 20, 0);
    tbl[6]  = mk(4'h1, 32'h000000A5, 0, 0, 0, 0, 4'h0, 32'h0, 4'h1, 32'h000000A5, 20, 1);
    tbl[7]  = mk(4'h3, 32'h0000BEEF, 0, 0, 0, 0, 4'h0, 32'h0, 4'h3, 32'h0000BEEF, 20, 3);
    tbl[8]  = mk(4'hF, 32'h12345678, 0, 1, 0, 0, 4'h0, 32'h0, 4'hF, 32'h12345678, 0, 0);
    tbl[9]  = mk(4'h0, 32'h0,        1, 0, 0, 1, 4'h0, 32'h0, 4'h0, 0, 0, 0);
    tbl[10] = mk(4'h0, 32'h0,        1, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 0);
    tbl[11] = mk(4'hF, 32'hCAFEBABE, 0, 0, 1, 1, 4'hF, 32'hCAFEBABE, 4'h0, 0, 4, 0);
    tbl[12] = mk(4'h5, 32'h0A0B0C0D, 0, 0, 1, 1, 4'h5, 32'h0A0B0C0D, 4'h0, 0, 6, 0);
    tbl[13] = mk(4'h2, 32'h01010101, 1, 0, 1, 0, 4'h2, 32'h01010101, 4'h0, 0, 7, 0);
    tbl[14] = mk(4'h0, 32'h0,        1, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 7, 0);
    tbl[15] = mk(4'hF, 32'h0,        0, 0, 1, 1, 4'hF, 32'h0, 4'h0, 0, 11, 0);
    tbl[16] = mk(4'hF, 32'h0,        1, 0, 1, 0, 4'hF, 32'h0, 4'h0, 0, 15, 0);
    tbl[17] = mk(4'hF, 32'h0,        0, 0, 1, 1, 4'hF, 32'h0, 4'h0, 0, 19, 0);
    tbl[18] = mk(4'hF, 32'h0,        1, 0, 1, 0, 4'hF, 32'h0, 4'h0, 0, 23, 0);

    gap_v[0] = 4'hF; gap_v[1] = 4'h0; gap_v[2] = 4'h0; gap_v[3] = 4'h1;
    gap_v[4] = 4'h0; gap_v[5] = 4'h0; gap_v[6] = 4'h0;

    // Reset held with live traffic.
    rst = 1'b1; in_valid = 4'hF; in_data = 32'hDEADBEEF; recirc_sel = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", {a_route, a_pend, a_mv, a_pv}, {1'b1, 1'b0, 4'h0, 4'h0});
    check("rst_data", {a_md, a_pd}, 64'h0);
    check("rst_cnt", {a_mb, a_pb}, 32'h0);
    rst = 1'b0; in_data = 32'h44332211;
    step();
    check("post_rst_data", {a_mv, a_md, a_mb}, {4'hF, 32'h44332211, 16'd4});
    recirc_sel = 1'b0;
    step();
    check("drain_pend", {a_route, a_pend, a_mb}, {1'b1, 1'b1, 16'd8});
    #2 rst = 1'b1;
    #1 check("rst_mid_drain", {a_route, a_pend, a_mv, a_md, a_mb}, {2'b10, 4'h0, 32'h0, 16'h0});
    recirc_sel = 1'b1; in_valid = '0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].valid; in_data = tbl[i].data;
      recirc_sel = tbl[i].sel; cnt_clr = tbl[i].clr;
      step();
      check($sformatf("v%0d_ctl", i), {a_route, a_pend, a_mv, a_pv},
            {tbl[i].e_route, tbl[i].e_pend, tbl[i].e_mv, tbl[i].e_pv});
      check($sformatf("v%0d_mdata", i), a_md, tbl[i].e_md);
      check($sformatf("v%0d_pdata", i), a_pd, tbl[i].e_pd);
      check($sformatf("v%0d_mbeats", i), a_mb, tbl[i].e_mb);
      check($sformatf("v%0d_pbeats", i), a_pb, tbl[i].e_pb);
    end
    cnt_clr = 1'b0;

    // GAP_CYC=3: busy, 2 idle, 1 busy, 3 idle; commit only on the third idle in a row.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      in_valid = gap_v[c]; in_data = '0; recirc_sel = 1'b0;
      step();
      check($sformatf("gap%0d", c), {b_route, b_pend, b_pv},
            {(c < 6) ? 1'b1 : 1'b0, (c < 6) ? 1'b1 : 1'b0, 4'h0});
    end
    in_valid = 4'h1; in_data = 32'h000000A5;
    step();
    check("gap_first_prb", {b_mv, b_pv, b_pd}, {4'h0, 4'h1, 32'h000000A5});

    // CNT_W=4 saturation and clear-over-increment.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = 4'hF; in_data = 32'h0F0F0F0F;
      step();
      check($sformatf("sat%0d", c), b_mb, (c < 3) ? 4'(4 * (c + 1)) : 4'd15);
    end
    cnt_clr = 1'b1;
    step();
    check("clr_wins", {b_mb, b_pb}, 8'h00);
    cnt_clr = 1'b0;
    step();
    check("after_clr", b_mb, 4'd4);

    // Random traffic and route requests against a cycle model of the GAP_CYC=1 instance.
    do_reset();
    m_route = 1'b1; m_pend = 1'b0; m_mb = 0; m_pb = 0; total = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      in_data = $urandom;
      if ($urandom_range(0, 7) == 0) recirc_sel = ~recirc_sel;
      exp_mv = m_route ? in_valid : 4'h0;
      exp_md = m_route ? in_data : 32'h0;
      exp_pv = m_route ? 4'h0 : in_valid;
      exp_pd = m_route ? 32'h0 : in_data;
      total += $countones(in_valid);
      if (m_route) m_mb += $countones(in_valid);
      else m_pb += $countones(in_valid);
      if (!m_pend) begin
        if (recirc_sel != m_route) m_pend = 1'b1;
      end else if (recirc_sel == m_route) begin
        m_pend = 1'b0;
      end else if (in_valid == 4'h0) begin
        m_route = ~m_route;
        m_pend = 1'b0;
      end
      step();
      check($sformatf("rnd%0d_out", c), {a_route, a_pend, a_mv, a_md, a_pv, a_pd},
            {m_route, m_pend, exp_mv, exp_md, exp_pv, exp_pd});
      check($sformatf("rnd%0d_cnt", c), {a_mb, a_pb}, {16'(m_mb), 16'(m_pb)});
    end
    check("rnd_total", 32'(a_mb) + 32'(a_pb), 32'(total));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
